// File: rtl/uart_pattern_pkg.sv
// Shared types and the next-value rule for the UART pattern source and its receive checker.
package uart_pattern_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_DONE,
      GAP,
      DONE
   } state_t;

   localparam int unsigned MODE_INC   = 0;
   localparam int unsigned MODE_CONST = 1;
   localparam int unsigned MODE_ROT   = 2;

   // Values are carried in 32 bits and masked to the real data width on return.
   function automatic logic [31:0] next_value(
      input logic [31:0] data,
      input int unsigned mode,
      input logic [31:0] first,
      input logic [31:0] last,
      input logic [31:0] wrap,
      input int unsigned width
   );
      logic [31:0] mask;
      logic [31:0] res;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      res  = '0;
      case (mode)
         MODE_CONST: res = first;
         MODE_ROT:   res = (data << 1) | ((data & mask) >> (width - 1));
         default:    res = (data >= last) ? wrap : (data + 32'd1);
      endcase
      return res & mask;
   endfunction

endpackage

// File: rtl/uart_pattern_checker.sv
// Receive-side checker: tracks the expected pattern and counts received bytes and mismatches.
module uart_pattern_checker
   import uart_pattern_pkg::*;
#(
   parameter int unsigned          DATA_W    = 8,
   parameter logic [DATA_W-1:0]    FIRST_VAL = DATA_W'(8'hC2),
   parameter logic [DATA_W-1:0]    LAST_VAL  = DATA_W'(8'hC4),
   parameter logic [DATA_W-1:0]    WRAP_VAL  = DATA_W'(8'h00),
   parameter int unsigned          MODE      = 0
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_seed,
   input  logic              i_rx_valid,
   input  logic [DATA_W-1:0] i_rx_byte,
   output logic [15:0]       o_rx_cnt,
   output logic [15:0]       o_err_cnt
);

   logic [DATA_W-1:0] r_exp;
   logic [15:0]       r_rx_cnt;
   logic [15:0]       r_err_cnt;
   logic              w_match;
   logic [DATA_W-1:0] w_next_exp;
   logic [DATA_W-1:0] w_next_rx;

   assign w_match    = (i_rx_byte == r_exp);
   assign w_next_exp = DATA_W'(next_value(32'(r_exp), MODE, 32'(FIRST_VAL),
                                          32'(LAST_VAL), 32'(WRAP_VAL), DATA_W));
   assign w_next_rx  = DATA_W'(next_value(32'(i_rx_byte), MODE, 32'(FIRST_VAL),
                                          32'(LAST_VAL), 32'(WRAP_VAL), DATA_W));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_exp     <= FIRST_VAL;
         r_rx_cnt  <= '0;
         r_err_cnt <= '0;
      end else begin
         if (i_rx_valid) begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
            if (!w_match && (r_err_cnt != '1)) begin
               r_err_cnt <= r_err_cnt + 16'd1;
            end
         end
         // A new burst restarts the sequence, overriding any late byte of the previous one.
         if (i_seed) begin
            r_exp <= FIRST_VAL;
         end else if (i_rx_valid) begin
            r_exp <= w_match ? w_next_exp : w_next_rx;
         end
      end
   end

   assign o_rx_cnt  = r_rx_cnt;
   assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/uart_pattern_source.sv
// Programmable byte-pattern source for a uart_tx start/done handshake with burst and stall handling.
// Define UART_PATTERN_CHECK_EN to build in the receive-side pattern checker.
module uart_pattern_source
   import uart_pattern_pkg::*;
#(
   parameter int unsigned          DATA_W         = 8,
   parameter logic [DATA_W-1:0]    FIRST_VAL      = DATA_W'(8'hC2),
   parameter logic [DATA_W-1:0]    LAST_VAL       = DATA_W'(8'hC4),
   parameter logic [DATA_W-1:0]    WRAP_VAL       = DATA_W'(8'h00),
   parameter int unsigned          MODE           = 0,
   parameter int unsigned          GAP_CYCLES     = 31,
   parameter int unsigned          TIMEOUT_CYCLES = 4096
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_enable,
   input  logic [15:0]       i_burst_len,
   output logic              o_start,
   output logic [DATA_W-1:0] o_data,
   input  logic              i_done,
   output logic              o_tdo,
   output logic [15:0]       o_byte_cnt,
   output logic              o_burst_done,
   output logic              o_timeout,
   input  logic              i_rx_valid,
   input  logic [DATA_W-1:0] i_rx_byte,
   output logic [15:0]       o_rx_cnt,
   output logic [15:0]       o_err_cnt
);

   localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam int unsigned TO_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_data;
   logic [15:0]       r_byte_cnt;
   logic              r_tdo;
   logic              r_timeout;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic [TO_W-1:0]   r_to_cnt;

   logic              w_load;
   logic              w_adv;
   logic              w_to_set;
   logic              w_start;
   logic              w_burst_done;
   logic              w_gap_hit;
   logic              w_to_hit;
   logic [15:0]       w_cnt_inc;
   logic [DATA_W-1:0] w_data_nxt;

   assign w_gap_hit  = (r_gap_cnt == GAP_W'(GAP_CYCLES));
   assign w_to_hit   = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign w_cnt_inc  = r_byte_cnt + 16'd1;
   assign w_data_nxt = DATA_W'(next_value(32'(r_data), MODE, 32'(FIRST_VAL),
                                          32'(LAST_VAL), 32'(WRAP_VAL), DATA_W));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_load       = 1'b0;
      w_adv        = 1'b0;
      w_to_set     = 1'b0;
      w_start      = 1'b0;
      w_burst_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_enable) begin
               w_load      = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            w_start     = 1'b1;
            w_state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_done) begin
               w_adv = 1'b1;
               if ((i_burst_len != '0) && (w_cnt_inc == i_burst_len)) begin
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = GAP;
               end
            end else if (w_to_hit) begin
               w_to_set    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         GAP: begin
            if (w_gap_hit) begin
               w_state_nxt = i_enable ? START : IDLE;
            end
         end
         DONE: begin
            w_burst_done = 1'b1;
            if (!i_enable) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Gap counter spans GAP_CYCLES+1 cycles in GAP; timeout counter spans TIMEOUT_CYCLES in WAIT_DONE.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_data     <= FIRST_VAL;
         r_byte_cnt <= '0;
         r_tdo      <= 1'b1;
         r_timeout  <= 1'b0;
         r_gap_cnt  <= '0;
         r_to_cnt   <= '0;
      end else begin
         if (w_load) begin
            r_data     <= FIRST_VAL;
            r_byte_cnt <= '0;
            r_timeout  <= 1'b0;
         end else if (w_adv) begin
            r_data     <= w_data_nxt;
            r_byte_cnt <= w_cnt_inc;
            r_tdo      <= ~r_tdo;
         end
         if (w_to_set) begin
            r_timeout <= 1'b1;
         end
         if ((r_state == GAP) && !w_gap_hit) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
         end else begin
            r_gap_cnt <= '0;
         end
         if ((r_state == WAIT_DONE) && !i_done && !w_to_hit) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end else begin
            r_to_cnt <= '0;
         end
      end
   end

   assign o_start      = w_start;
   assign o_data       = r_data;
   assign o_tdo        = r_tdo;
   assign o_byte_cnt   = r_byte_cnt;
   assign o_burst_done = w_burst_done;
   assign o_timeout    = r_timeout;

`ifdef UART_PATTERN_CHECK_EN
   uart_pattern_checker #(
      .DATA_W   (DATA_W),
      .FIRST_VAL(FIRST_VAL),
      .LAST_VAL (LAST_VAL),
      .WRAP_VAL (WRAP_VAL),
      .MODE     (MODE)
   ) u_checker (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_seed    (w_load),
      .i_rx_valid(i_rx_valid),
      .i_rx_byte (i_rx_byte),
      .o_rx_cnt  (o_rx_cnt),
      .o_err_cnt (o_err_cnt)
   );
`else
   logic w_unused;
   assign w_unused  = &{1'b0, i_rx_valid, i_rx_byte};
   assign o_rx_cnt  = '0;
   assign o_err_cnt = '0;
`endif

endmodule
